// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - shared VGA 640x480@60 timing constants and coordinate type
//
// Purpose: default raster timing shared by the sync generator, the GPU top
// level and its delay pipeline, plus the 10-bit coordinate type and a small
// half-open window decode helper.
package vga_sync_gen_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // True when lo <= v < hi. The coordinate is widened by one bit so a window
  // ending exactly at 1024 still decodes correctly.
  function automatic logic in_window(input logic [COORD_W:0] v,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (v >= (COORD_W+1)'(lo)) && (v < (COORD_W+1)'(hi));
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - pixel tick generator dividing the system clock by CLK_DIV
//
// Purpose: counts 0..CLK_DIV-1 and flags the last count as the pixel tick.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (counter to 0)
//   tick_o  high for one clk_i cycle every CLK_DIV cycles; constant 1 when CLK_DIV==1
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == DIV_LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator (counters, sync and blanking decode)
//
// Purpose: advances x/y raster counters on each pixel tick and produces
// registered sync, active-video and start-of-vertical-blanking flags.
// Ports:
//   clk_i             system clock
//   rst_ni            asynchronous active-low reset, raster restarts at (0,0)
//   pix_tick_o        one-cycle pulse when the counters advance
//   x_o / y_o         current column / line
//   h_sync_o          horizontal sync, active low
//   v_sync_o          vertical sync, active low
//   active_o          high inside the visible area
//   blanking_start_o  one pixel period high at (0, V_VISIBLE)
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned CLK_DIV   = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic         pix_tick_o,
  output logic [9:0]   x_o,
  output logic [9:0]   y_o,
  output logic         h_sync_o,
  output logic         v_sync_o,
  output logic         active_o,
  output logic         blanking_start_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;

  logic   tick;
  coord_t x_q, x_d, y_q, y_d;
  logic   h_sync_q, h_sync_d;
  logic   v_sync_q, v_sync_d;
  logic   active_q, active_d;
  logic   blank_q, blank_d;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
  end

  // Flags decode the next coordinates so they register on the same edge as
  // the counters and never lag x_o/y_o.
  always_comb begin
    h_sync_d = !in_window({1'b0, x_d}, HS_START, HS_START + H_SYNC);
    v_sync_d = !in_window({1'b0, y_d}, VS_START, VS_START + V_SYNC);
    active_d = in_window({1'b0, x_d}, 0, H_VISIBLE) &&
               in_window({1'b0, y_d}, 0, V_VISIBLE);
    blank_d  = (x_d == '0) && ({1'b0, y_d} == (COORD_W+1)'(V_VISIBLE));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q      <= '0;
      y_q      <= '0;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
      active_q <= 1'b1;
      blank_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      active_q <= active_d;
      blank_q  <= blank_d;
    end
  end

  assign pix_tick_o       = tick;
  assign x_o              = x_q;
  assign y_o              = y_q;
  assign h_sync_o         = h_sync_q;
  assign v_sync_o         = v_sync_q;
  assign active_o         = active_q;
  assign blanking_start_o = blank_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen (default, custom and divide-by-4 rasters)
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_c, rst_d;
  logic en_a, en_c, en_d;

  logic       tka, hsa, vsa, aca, bsa;
  logic [9:0] xa, ya;
  logic       tkc, hsc, vsc, acc, bsc;
  logic [9:0] xc, yc;
  logic       tkd, hsd, vsd, acd, bsd;
  logic [9:0] xd, yd;

  vga_sync_gen u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .pix_tick_o(tka), .x_o(xa), .y_o(ya),
    .h_sync_o(hsa), .v_sync_o(vsa), .active_o(aca), .blanking_start_o(bsa)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(1)
  ) u_dut_c (
    .clk_i(clk), .rst_ni(rst_c), .pix_tick_o(tkc), .x_o(xc), .y_o(yc),
    .h_sync_o(hsc), .v_sync_o(vsc), .active_o(acc), .blanking_start_o(bsc)
  );

  vga_sync_gen #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(4)
  ) u_dut_d (
    .clk_i(clk), .rst_ni(rst_d), .pix_tick_o(tkd), .x_o(xd), .y_o(yd),
    .h_sync_o(hsd), .v_sync_o(vsd), .active_o(acd), .blanking_start_o(bsd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Packed {x, y, h_sync, v_sync, active, blanking_start} for pixel n after reset.
  function automatic logic [23:0] exp_pix(input int n, input int ht, input int vt,
                                          input int hs_lo, input int hs_hi,
                                          input int vs_lo, input int vs_hi,
                                          input int hvis, input int vvis);
    int x, y;
    x = n % ht;
    y = (n / ht) % vt;
    return {10'(x), 10'(y), !(x >= hs_lo && x < hs_hi), !(y >= vs_lo && y < vs_hi),
            (x < hvis && y < vvis), (x == 0 && y == vvis)};
  endfunction

  logic [23:0] qa[$], qc[$], qd[$];
  logic [23:0] ea, ec, ed;

  int pa = 0, act_a = 0, hsl_a = 0;
  int pc = 0, bs_c = 0, vsl_c = 0;
  int pd = 0, kd = 0, k0 = 0, k800 = 0, bs_d = 0;

  always @(negedge clk) begin
    if (en_a && tka && qa.size() > 0) begin
      ea = qa.pop_front();
      check("a_pixel", {xa, ya, hsa, vsa, aca, bsa}, ea);
      if (pa < 800) begin
        act_a += int'(aca);
        hsl_a += int'(!hsa);
      end
      pa++;
    end
  end

  always @(negedge clk) begin
    if (en_c && tkc && qc.size() > 0) begin
      ec = qc.pop_front();
      check("c_pixel", {xc, yc, hsc, vsc, acc, bsc}, ec);
      check("c_blank_vs_active", bsc & acc, 0);
      bs_c  += int'(bsc);
      vsl_c += int'(!vsc);
      pc++;
    end
  end

  always @(negedge clk) begin
    if (en_d) begin
      check("d_tick", tkd, (kd % 4 == 3));
      bs_d += int'(bsd);
      if (tkd && qd.size() > 0) begin
        ed = qd.pop_front();
        check("d_pixel", {xd, yd, hsd, vsd, acd, bsd}, ed);
        if (pd == 0)   k0   = kd;
        if (pd == 800) k800 = kd;
        pd++;
      end
      kd++;
    end
  end

  initial begin
    for (int n = 0; n < 1000; n++) qa.push_back(exp_pix(n, 800, 525, 656, 752, 490, 492, 640, 480));
    for (int n = 0; n < 225; n++)  qc.push_back(exp_pix(n, 16, 7, 10, 13, 5, 6, 8, 4));
    for (int n = 0; n < 5601; n++) qd.push_back(exp_pix(n, 800, 7, 656, 752, 5, 6, 640, 4));

    rst_a = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    en_a = 1'b0; en_c = 1'b0; en_d = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("a_reset_state", {xa, ya, hsa, vsa, aca, bsa, tka}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    check("c_reset_state", {xc, yc, hsc, vsc, acc, bsc, tkc}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    check("d_reset_state", {xd, yd, hsd, vsd, acd, bsd, tkd}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});

    @(posedge clk);
    #2;
    rst_a = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    en_a = 1'b1; en_c = 1'b1; en_d = 1'b1;

    fork
      begin : br_a
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
          @(negedge clk);
          if (qa.size() == 0 && ya == 10'd1 && xa == 10'd300) found = 1'b1;
        end
        check("a_reach_x300_line1", found, 1);
        en_a = 1'b0;
        #2 rst_a = 1'b0;
        #1 check("a_async_reset_midline", {xa, ya, hsa, vsa, aca, bsa}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
      end
      begin : br_cd
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30000 && !done; i++) begin
          @(negedge clk);
          if (qc.size() == 0 && qd.size() == 0) done = 1'b1;
        end
        check("cd_queues_drained", done, 1);
        en_c = 1'b0;
        en_d = 1'b0;
      end
    join

    check("a_active_clocks_line0", act_a, 640);
    check("a_hsync_low_clocks_line0", hsl_a, 96);
    check("a_queue_left", qa.size(), 0);
    check("c_blank_pulses_2frames", bs_c, 2);
    check("c_vsync_low_clocks_2frames", vsl_c, 32);
    check("d_line_clocks", k800 - k0, 3200);
    check("d_blank_width_clocks", bs_d, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
